// File: rtl/msdf_digit_serializer_pkg.sv
// msdf_digit_serializer_pkg: radix-2 signed-digit encodings shared by the MSDF serializer and its users.
package msdf_digit_serializer_pkg;
    // Same code points as the R2_* set in Bit_rep.vh; 2'b10 is never produced.
    localparam logic [1:0] R2_ZERO    = 2'b00;
    localparam logic [1:0] R2_POS_ONE = 2'b01;
    localparam logic [1:0] R2_NEG_ONE = 2'b11;

    function automatic int r2_to_int(input logic [1:0] d);
        return d == R2_POS_ONE ? 1 : d == R2_NEG_ONE ? -1 : 0;
    endfunction
endpackage

// File: rtl/msdf_digit_serializer_if.sv
// msdf_digit_serializer_if: load/digit handshake bundle; neg exists only with MSDF_SER_NEG_EN.
interface msdf_digit_serializer_if #(parameter int N = 8);
    logic         start;
    logic [N-1:0] din;
    logic         ready;
    logic         dig_valid;
    logic         dig_ready;
    logic [1:0]   dig_out;
    logic         dig_last;
`ifdef MSDF_SER_NEG_EN
    logic         neg;
    modport master(output start, din, neg, dig_ready, input ready, dig_valid, dig_out, dig_last);
    modport slave(input start, din, neg, dig_ready, output ready, dig_valid, dig_out, dig_last);
`else
    modport master(output start, din, dig_ready, input ready, dig_valid, dig_out, dig_last);
    modport slave(input start, din, dig_ready, output ready, dig_valid, dig_out, dig_last);
`endif
endinterface

// File: rtl/msdf_sd_recode.sv
// msdf_sd_recode: Booth bit pair (b[k], b[k-1]) to signed digit, optionally negated.
module msdf_sd_recode
    import msdf_digit_serializer_pkg::*;
(
    input  logic [1:0] pair,
    input  logic       neg,
    output logic [1:0] dig
);
    assign dig = pair == 2'b01 ? (neg ? R2_NEG_ONE : R2_POS_ONE) :
                 pair == 2'b10 ? (neg ? R2_POS_ONE : R2_NEG_ONE) : R2_ZERO;
endmodule

// File: rtl/msdf_digit_serializer.sv
// msdf_digit_serializer: N-bit two's-complement word to MSD-first radix-2 signed digits.
// Define MSDF_SER_NEG_EN to add the neg input that emits -din instead of din.
module msdf_digit_serializer
    import msdf_digit_serializer_pkg::*;
#(
    parameter int N = 8
) (
    input logic clk,
    input logic rst,
    msdf_digit_serializer_if.slave s
);
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        st;
    logic [N:0]    sr;
    logic [CW-1:0] cnt;
    logic          neg_r;
    logic          neg_in;
    logic          last;
    logic          rdy;
    logic [1:0]    pair;

`ifdef MSDF_SER_NEG_EN
    assign neg_in = s.neg;
`else
    assign neg_in = 1'b0;
`endif

    assign last        = st == SHIFT && cnt == '0;
    assign rdy         = st == IDLE || (last && s.dig_ready);
    assign s.ready     = rdy;
    assign s.dig_valid = st == SHIFT;
    assign s.dig_last  = last;
    // Gating the pair keeps dig_out at zero whenever no digit is offered.
    assign pair        = st == SHIFT ? sr[N:N-1] : 2'b00;

    msdf_sd_recode u_recode (
        .pair(pair),
        .neg (neg_r),
        .dig (s.dig_out)
    );

    // A start accepted on the last consume reloads directly, so SHIFT has no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            neg_r <= 1'b0;
        end else if (s.start && rdy) begin
            st    <= SHIFT;
            sr    <= {s.din, 1'b0};
            cnt   <= CW'(N - 1);
            neg_r <= neg_in;
        end else if (st == SHIFT && s.dig_ready) begin
            sr  <= sr << 1;
            cnt <= cnt - 1'b1;
            if (last) st <= IDLE;
        end
    end
endmodule

// File: tb/tb_msdf_digit_serializer.sv
// tb_msdf_digit_serializer: scoreboard bench for the MSDF digit serializer (N=8).
module tb_msdf_digit_serializer;
    import msdf_digit_serializer_pkg::*;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    msdf_digit_serializer_if #(.N(N)) ifc();
    msdf_digit_serializer #(.N(N)) dut (.clk(clk), .rst(rst), .s(ifc));

    int errs = 0;
    int checks = 0;
    logic nf = 1'b0;
    logic [1:0] q_d[$];
    logic q_l[$];
    logic [1:0] ed;
    logic el;

    // Booth model: d_k = b[k-1] - b[k], b[-1] = 0, MSD first.
    task automatic push_word(input logic [N-1:0] w, input logic ng);
        for (int k = N - 1; k >= 0; k--) begin
            int d;
            d = (k > 0 ? int'(w[k-1]) : 0) - int'(w[k]);
            if (ng) d = -d;
            q_d.push_back(d == 1 ? R2_POS_ONE : d == -1 ? R2_NEG_ONE : R2_ZERO);
            q_l.push_back(k == 0);
        end
    endtask

    task automatic issue(input logic [N-1:0] w);
        ifc.din = w;
        ifc.start = 1'b1;
`ifdef MSDF_SER_NEG_EN
        ifc.neg = nf;
`endif
        push_word(w, nf);
        @(posedge clk);
        #1 ifc.start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (ifc.ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", ifc.ready); end
        if (ifc.dig_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", ifc.dig_valid); end
        if (ifc.dig_out !== R2_ZERO) begin errs++; $display("FAIL reset_dig: got %b want %b", ifc.dig_out, R2_ZERO); end
        if (ifc.dig_last !== 1'b0) begin errs++; $display("FAIL reset_last: got %b want 0", ifc.dig_last); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_words();
        logic [N-1:0] ws[3] = '{8'h05, 8'h80, 8'hFF};
        foreach (ws[j]) begin
            issue(ws[j]);
            for (int i = 0; i < N; i++) begin
                @(negedge clk);
                ed = q_d.pop_front();
                el = q_l.pop_front();
                checks += 4;
                if (ifc.dig_valid !== 1'b1) begin errs++; $display("FAIL word_valid %h[%0d]: got %b want 1", ws[j], i, ifc.dig_valid); end
                if (ifc.dig_out !== ed) begin errs++; $display("FAIL word_dig %h[%0d]: got %b want %b", ws[j], i, ifc.dig_out, ed); end
                if (ifc.dig_last !== el) begin errs++; $display("FAIL word_last %h[%0d]: got %b want %b", ws[j], i, ifc.dig_last, el); end
                if (ifc.ready !== el) begin errs++; $display("FAIL word_ready %h[%0d]: got %b want %b", ws[j], i, ifc.ready, el); end
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            checks += 2;
            if (ifc.ready !== 1'b1) begin errs++; $display("FAIL word_end_ready %h: got %b want 1", ws[j], ifc.ready); end
            if (ifc.dig_valid !== 1'b0) begin errs++; $display("FAIL word_end_valid %h: got %b want 0", ws[j], ifc.dig_valid); end
            @(posedge clk);
            #1;
        end
    endtask

    // Stall after the third digit; a start pulse during the stall must be dropped.
    task automatic test_backpressure();
        issue(8'h05);
        for (int i = 0; i < N + 3; i++) begin
            ifc.dig_ready = !(i >= 3 && i < 6);
            ifc.start = (i == 4);
            ifc.din = 8'hAA;
            @(negedge clk);
            if (ifc.dig_ready) begin
                ed = q_d.pop_front();
                el = q_l.pop_front();
            end else begin
                ed = q_d[0];
                el = q_l[0];
            end
            checks += 3;
            if (ifc.dig_valid !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d]: got %b want 1", i, ifc.dig_valid); end
            if (ifc.dig_out !== ed) begin errs++; $display("FAIL bp_dig[%0d]: got %b want %b", i, ifc.dig_out, ed); end
            if (ifc.dig_last !== el) begin errs++; $display("FAIL bp_last[%0d]: got %b want %b", i, ifc.dig_last, el); end
            @(posedge clk);
            #1;
        end
        ifc.start = 1'b0;
        ifc.dig_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ifc.dig_valid !== 1'b0) begin errs++; $display("FAIL bp_end_valid: got %b want 0", ifc.dig_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        issue(8'h05);
        for (int i = 0; i < 2 * N; i++) begin
            if (i == N - 1) begin
                ifc.start = 1'b1;
                ifc.din = 8'h03;
                push_word(8'h03, nf);
            end
            @(negedge clk);
            ed = q_d.pop_front();
            el = q_l.pop_front();
            checks += 3;
            if (ifc.dig_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, ifc.dig_valid); end
            if (ifc.dig_out !== ed) begin errs++; $display("FAIL b2b_dig[%0d]: got %b want %b", i, ifc.dig_out, ed); end
            if (ifc.dig_last !== el) begin errs++; $display("FAIL b2b_last[%0d]: got %b want %b", i, ifc.dig_last, el); end
            if (i == N - 1) begin
                checks++;
                if (ifc.ready !== 1'b1) begin errs++; $display("FAIL b2b_ready: got %b want 1", ifc.ready); end
            end
            @(posedge clk);
            #1 ifc.start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (ifc.dig_valid !== 1'b0) begin errs++; $display("FAIL b2b_end_valid: got %b want 0", ifc.dig_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        issue(8'h05);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ed = q_d.pop_front();
            el = q_l.pop_front();
            checks++;
            if (ifc.dig_out !== ed) begin errs++; $display("FAIL rm_pre_dig[%0d]: got %b want %b", i, ifc.dig_out, ed); end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q_d.delete();
        q_l.delete();
        @(negedge clk);
        checks += 4;
        if (ifc.ready !== 1'b1) begin errs++; $display("FAIL rm_ready: got %b want 1", ifc.ready); end
        if (ifc.dig_valid !== 1'b0) begin errs++; $display("FAIL rm_valid: got %b want 0", ifc.dig_valid); end
        if (ifc.dig_out !== R2_ZERO) begin errs++; $display("FAIL rm_dig: got %b want %b", ifc.dig_out, R2_ZERO); end
        if (ifc.dig_last !== 1'b0) begin errs++; $display("FAIL rm_last: got %b want 0", ifc.dig_last); end
        @(posedge clk);
        #1;
        issue(8'h7F);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ed = q_d.pop_front();
            el = q_l.pop_front();
            checks += 2;
            if (ifc.dig_out !== ed) begin errs++; $display("FAIL rm_7f_dig[%0d]: got %b want %b", i, ifc.dig_out, ed); end
            if (ifc.dig_last !== el) begin errs++; $display("FAIL rm_7f_last[%0d]: got %b want %b", i, ifc.dig_last, el); end
            @(posedge clk);
            #1;
        end
    endtask

    // Accumulate the stream as a CA_REG #(N+1) would and compare with the signed word.
    task automatic test_loopback();
`ifdef MSDF_SER_NEG_EN
        nf = 1'b1;
`endif
        for (int w = 0; w < 256; w++) begin
            logic [N-1:0] b;
            int val;
            int exp_v;
            b = N'(w);
            val = 0;
            issue(b);
            for (int i = 0; i < N; i++) begin
                @(negedge clk);
                ed = q_d.pop_front();
                el = q_l.pop_front();
                checks++;
                if (ifc.dig_out !== ed || ifc.dig_valid !== 1'b1) begin
                    errs++;
                    $display("FAIL lb_dig %h[%0d]: got %b/v%b want %b/v1", b, i, ifc.dig_out, ifc.dig_valid, ed);
                end
                val = val * 2 + r2_to_int(ifc.dig_out);
                @(posedge clk);
                #1;
            end
            exp_v = int'($signed(b));
            if (nf) exp_v = -exp_v;
            checks++;
            if (val !== exp_v) begin errs++; $display("FAIL lb_value %h: got %0d want %0d", b, val, exp_v); end
        end
        nf = 1'b0;
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.din = '0;
        ifc.dig_ready = 1'b1;
`ifdef MSDF_SER_NEG_EN
        ifc.neg = 1'b0;
`endif
        test_reset();
        test_words();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
